// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES chaining controller: FSM encoding,
// chaining/key/direction constants and the CBC masking helper.
package aes_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_KEY_REQ  = 3'd1,
      ST_KEY_WAIT = 3'd2,
      ST_RDY      = 3'd3,
      ST_RUN      = 3'd4,
      ST_HOLD     = 3'd5,
      ST_ERR      = 3'd6
   } state_e;

   localparam logic       CHAIN_ECB = 1'b0;
   localparam logic       CHAIN_CBC = 1'b1;
   localparam logic       ENDE_ENC  = 1'b0;
   localparam logic       ENDE_DEC  = 1'b1;
   localparam logic [1:0] KEY_128   = 2'd0;
   localparam logic [1:0] KEY_192   = 2'd1;
   localparam logic [1:0] KEY_256   = 2'd2;

   // Chaining value to XOR in, or zero when the path is not chained.
   function automatic logic [127:0] chain_mask(input logic use_chain, input logic [127:0] cv);
      return use_chain ? cv : 128'h0;
   endfunction

endpackage

// File: rtl/aes_ctrl_wdog.sv
// Response watchdog: counts cycles while enabled, clears whenever disabled,
// so every entry into a waiting state starts from zero.
module aes_ctrl_wdog
   import aes_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic armed_o,
   output logic expired_o
);

   localparam int unsigned W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Saturating count; dropping the enable reloads zero.
   always_comb begin
      if (!en_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Armed from the second waiting cycle on; expired once the limit is held.
   assign armed_o   = (cnt_q != '0);
   assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/aes_chain_ctrl.sv
// ECB/CBC chaining controller around an external AES core: key setup,
// one block in flight, output hold until the host takes it, response timeout.
module aes_chain_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1023,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_cfg_start,
   input  logic             i_ende,
   input  logic [1:0]       i_key_mode,
   input  logic             i_chain,
   input  logic [255:0]     i_key,
   input  logic [127:0]     i_iv,
   input  logic [127:0]     i_data,
   input  logic             i_data_valid,
   output logic             o_data_ready,
   output logic [127:0]     o_data,
   output logic             o_data_valid,
   input  logic             i_data_ready,
   output logic             o_cfg_done,
   output logic             o_error,
   output logic [CNT_W-1:0] o_block_cnt,
   output logic             o_core_start,
   output logic             o_core_enable,
   output logic             o_core_ende,
   output logic [255:0]     o_core_key,
   output logic [1:0]       o_core_key_mode,
   output logic [127:0]     o_core_data,
   output logic             o_core_data_valid,
   input  logic [127:0]     i_core_data,
   input  logic             i_core_data_valid,
   input  logic             i_core_key_ready
);

   state_e             state_q;
   logic               ende_q, chain_mode_q, enable_q;
   logic [1:0]         key_mode_q;
   logic [255:0]       key_q;
   logic [127:0]       cv_q, ct_q, core_data_q, data_q;
   logic               core_start_q, core_dv_q, data_valid_q, ready_q, cfg_done_q, error_q;
   logic [CNT_W-1:0]   blk_cnt_q;
   logic [127:0]       core_data_d, data_d;
   logic               cbc_enc_s, cbc_dec_s, wd_en_s, wd_armed_s, wd_expired_s;

   assign cbc_enc_s = (chain_mode_q == CHAIN_CBC) && (ende_q == ENDE_ENC);
   assign cbc_dec_s = (chain_mode_q == CHAIN_CBC) && (ende_q == ENDE_DEC);
   assign wd_en_s   = (state_q == ST_KEY_WAIT) || (state_q == ST_RUN);

   // CBC encrypt chains before the core, CBC decrypt chains after it.
   always_comb begin
      core_data_d = i_data ^ chain_mask(cbc_enc_s, cv_q);
      data_d      = i_core_data ^ chain_mask(cbc_dec_s, cv_q);
   end

   aes_ctrl_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (wd_en_s),
      .armed_o   (wd_armed_s),
      .expired_o (wd_expired_s)
   );

   // Controller FSM; a new configuration overrides whatever is in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ende_q       <= 1'b0;
         chain_mode_q <= CHAIN_ECB;
         key_mode_q   <= KEY_128;
         key_q        <= 256'h0;
         cv_q         <= 128'h0;
         ct_q         <= 128'h0;
         core_data_q  <= 128'h0;
         data_q       <= 128'h0;
         core_start_q <= 1'b0;
         core_dv_q    <= 1'b0;
         data_valid_q <= 1'b0;
         ready_q      <= 1'b0;
         cfg_done_q   <= 1'b0;
         error_q      <= 1'b0;
         enable_q     <= 1'b0;
         blk_cnt_q    <= '0;
      end else begin
         enable_q     <= 1'b1;
         core_start_q <= 1'b0;
         core_dv_q    <= 1'b0;
         if (i_cfg_start) begin
            ende_q       <= i_ende;
            chain_mode_q <= i_chain;
            key_mode_q   <= i_key_mode;
            key_q        <= i_key;
            cv_q         <= i_iv;
            ct_q         <= 128'h0;
            data_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            cfg_done_q   <= 1'b0;
            error_q      <= 1'b0;
            blk_cnt_q    <= '0;
            core_start_q <= 1'b1;
            state_q      <= ST_KEY_REQ;
         end else begin
            case (state_q)
               ST_KEY_REQ: state_q <= ST_KEY_WAIT;
               ST_KEY_WAIT: begin
                  if (i_core_key_ready && wd_armed_s) begin
                     cfg_done_q <= 1'b1;
                     blk_cnt_q  <= '0;
                     ready_q    <= 1'b1;
                     state_q    <= ST_RDY;
                  end else if (wd_expired_s) begin
                     error_q    <= 1'b1;
                     cfg_done_q <= 1'b0;
                     state_q    <= ST_ERR;
                  end
               end
               ST_RDY: begin
                  if (i_data_valid && ready_q) begin
                     core_data_q <= core_data_d;
                     core_dv_q   <= 1'b1;
                     ready_q     <= 1'b0;
                     if (cbc_dec_s) begin
                        ct_q <= i_data;
                     end
                     state_q <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (i_core_data_valid) begin
                     data_q       <= data_d;
                     data_valid_q <= 1'b1;
                     state_q      <= ST_HOLD;
                  end else if (wd_expired_s) begin
                     error_q    <= 1'b1;
                     cfg_done_q <= 1'b0;
                     state_q    <= ST_ERR;
                  end
               end
               ST_HOLD: begin
                  if (i_data_ready) begin
                     data_valid_q <= 1'b0;
                     blk_cnt_q    <= blk_cnt_q + CNT_W'(1);
                     if (cbc_enc_s) begin
                        cv_q <= data_q;
                     end else if (cbc_dec_s) begin
                        cv_q <= ct_q;
                     end
                     ready_q <= 1'b1;
                     state_q <= ST_RDY;
                  end
               end
               ST_IDLE, ST_ERR: state_q <= state_q;
               default:         state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_data_ready      = ready_q;
   assign o_data            = data_q;
   assign o_data_valid      = data_valid_q;
   assign o_cfg_done        = cfg_done_q;
   assign o_error           = error_q;
   assign o_block_cnt       = blk_cnt_q;
   assign o_core_start      = core_start_q;
   assign o_core_enable     = enable_q;
   assign o_core_ende       = ende_q;
   assign o_core_key        = key_q;
   assign o_core_key_mode   = key_mode_q;
   assign o_core_data       = core_data_q;
   assign o_core_data_valid = core_dv_q;

endmodule

// File: tb/tb_aes_chain_ctrl.sv
// Scoreboard bench for aes_chain_ctrl with a table-driven AES core model
// holding the known-answer vectors.
module tb_aes_chain_ctrl;

   localparam int unsigned TO = 40;

   localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] D0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] E0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;

   logic clk = 1'b0, rst_n = 1'b0;
   logic i_cfg_start = 1'b0, i_ende = 1'b0, i_chain = 1'b0;
   logic [1:0] i_key_mode = 2'd0;
   logic [255:0] i_key = 256'h0;
   logic [127:0] i_iv = 128'h0, i_data = 128'h0, i_core_data = 128'h0;
   logic i_data_valid = 1'b0, i_data_ready = 1'b1, i_core_data_valid = 1'b0, i_core_key_ready = 1'b0;
   logic o_data_ready, o_data_valid, o_cfg_done, o_error, o_core_start, o_core_enable;
   logic o_core_ende, o_core_data_valid;
   logic [127:0] o_data, o_core_data;
   logic [31:0] o_block_cnt;
   logic [255:0] o_core_key;
   logic [1:0] o_core_key_mode;

   int errors = 0, checks = 0;

   typedef struct {logic [127:0] data; logic [31:0] cnt;} exp_t;
   exp_t exp_q[$];
   logic cnt_pend = 1'b0;
   logic [31:0] cnt_exp = 32'd0;

   int kr_mode = 0;   // 0 normal, 1 never ready, 2 always ready
   int kr_cnt = 0, core_lat = 3, cd_cnt = 0;
   logic core_pend = 1'b0;
   logic [127:0] core_res = 128'h0;
   logic out_seen = 1'b0;

   aes_chain_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .i_cfg_start(i_cfg_start), .i_ende(i_ende),
      .i_key_mode(i_key_mode), .i_chain(i_chain), .i_key(i_key), .i_iv(i_iv),
      .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
      .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
      .o_cfg_done(o_cfg_done), .o_error(o_error), .o_block_cnt(o_block_cnt),
      .o_core_start(o_core_start), .o_core_enable(o_core_enable), .o_core_ende(o_core_ende),
      .o_core_key(o_core_key), .o_core_key_mode(o_core_key_mode), .o_core_data(o_core_data),
      .o_core_data_valid(o_core_data_valid), .i_core_data(i_core_data),
      .i_core_data_valid(i_core_data_valid), .i_core_key_ready(i_core_key_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Known-answer AES table; unknown requests return a value that matches nothing.
   function automatic logic [127:0] core_fn(input logic ende, input logic [255:0] key, input logic [127:0] blk);
      if (!ende && key == {K0, 128'h0} && blk == D0) return E0;
      if (!ende && key == {K1, 128'h0} && blk == (P1 ^ IV)) return C1;
      if (!ende && key == {K1, 128'h0} && blk == (P2 ^ C1)) return C2;
      if (ende && key == {K1, 128'h0} && blk == C1) return P1 ^ IV;
      if (ende && key == {K1, 128'h0} && blk == C2) return P2 ^ C1;
      return ~blk;
   endfunction

   // Core model: key-ready two cycles after start, fixed data latency.
   always @(negedge clk) begin
      i_core_data_valid = 1'b0;
      if (kr_mode == 2) begin
         i_core_key_ready = 1'b1;
      end else if (o_core_start) begin
         i_core_key_ready = 1'b0;
         kr_cnt = 2;
      end else if (kr_cnt > 0) begin
         kr_cnt--;
         if (kr_cnt == 0 && kr_mode == 0) i_core_key_ready = 1'b1;
      end
      if (o_core_data_valid) begin
         core_pend = 1'b1;
         cd_cnt = core_lat;
         core_res = core_fn(o_core_ende, o_core_key, o_core_data);
      end else if (core_pend) begin
         cd_cnt--;
         if (cd_cnt == 0) begin
            i_core_data_valid = 1'b1;
            i_core_data = core_res;
            core_pend = 1'b0;
         end
      end
   end

   // Monitor: pop and compare on every host output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cnt_pend) begin
            chk("block_cnt", {224'h0, o_block_cnt}, {224'h0, cnt_exp});
            cnt_pend = 1'b0;
         end
         if (o_data_valid) out_seen = 1'b1;
         if (o_data_valid && i_data_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", o_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("o_data", {128'h0, o_data}, {128'h0, e.data});
               cnt_pend = 1'b1;
               cnt_exp = e.cnt;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic ende, input logic chain, input logic [127:0] key, input logic [127:0] iv);
      i_cfg_start = 1'b1;
      i_ende = ende;
      i_chain = chain;
      i_key_mode = 2'd0;
      i_key = {key, 128'h0};
      i_iv = iv;
      tick();
      i_cfg_start = 1'b0;
   endtask

   task automatic wait_cfg();
      for (int i = 0; i < 20 && !o_cfg_done; i++) tick();
      chk("cfg_done", {255'h0, o_cfg_done}, 256'h1);
   endtask

   task automatic push(input logic [127:0] d, input logic [31:0] c);
      exp_t e;
      e.data = d;
      e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [127:0] d);
      int n;
      i_data = d;
      i_data_valid = 1'b1;
      for (n = 0; n < 100 && !o_data_ready; n++) tick();
      if (n == 100) chk("send_ready_timeout", {255'h0, o_data_ready}, 256'h1);
      tick();
      i_data_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (exp_q.size() != 0 || cnt_pend); i++) tick();
      tick();
      chk("drain", 256'(exp_q.size()), 256'h0);
   endtask

   initial begin
      logic [127:0] held;
      logic stable, no_rdy, no_req;

      #12;
      chk("rst_data_ready", {255'h0, o_data_ready}, 256'h0);
      chk("rst_data_valid", {255'h0, o_data_valid}, 256'h0);
      chk("rst_cfg_done", {255'h0, o_cfg_done}, 256'h0);
      chk("rst_error", {255'h0, o_error}, 256'h0);
      chk("rst_core_start", {255'h0, o_core_start}, 256'h0);
      chk("rst_core_dv", {255'h0, o_core_data_valid}, 256'h0);
      chk("rst_core_enable", {255'h0, o_core_enable}, 256'h0);
      chk("rst_block_cnt", {224'h0, o_block_cnt}, 256'h0);
      chk("rst_core_key", o_core_key, 256'h0);
      #3 rst_n = 1'b1;
      tick();
      chk("core_enable", {255'h0, o_core_enable}, 256'h1);

      // ECB encrypt with key-ready already high: done only after the armed cycle.
      kr_mode = 2;
      cfg(1'b0, 1'b0, K0, 128'h0);
      chk("core_start_pulse", {255'h0, o_core_start}, 256'h1);
      tick();
      chk("core_start_drop", {255'h0, o_core_start}, 256'h0);
      tick();
      chk("cfg_done_early", {255'h0, o_cfg_done}, 256'h0);
      tick();
      chk("cfg_done_armed", {255'h0, o_cfg_done}, 256'h1);
      chk("core_key", o_core_key, {K0, 128'h0});
      push(E0, 32'd1);
      send(D0);
      drain();

      // Output held for 20 cycles with the host stalled.
      i_data_ready = 1'b0;
      push(E0, 32'd2);
      send(D0);
      for (int i = 0; i < 50 && !o_data_valid; i++) tick();
      held = o_data;
      stable = 1'b1; no_rdy = 1'b1; no_req = 1'b1;
      i_data_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_data !== held || o_data_valid !== 1'b1) stable = 1'b0;
         if (o_data_ready !== 1'b0) no_rdy = 1'b0;
         if (o_core_data_valid !== 1'b0) no_req = 1'b0;
      end
      i_data_valid = 1'b0;
      chk("hold_data", {128'h0, held}, {128'h0, E0});
      chk("hold_stable", {255'h0, stable}, 256'h1);
      chk("hold_no_ready", {255'h0, no_rdy}, 256'h1);
      chk("hold_no_core_req", {255'h0, no_req}, 256'h1);
      i_data_ready = 1'b1;
      drain();

      // CBC encrypt then decrypt.
      kr_mode = 0;
      cfg(1'b0, 1'b1, K1, IV);
      wait_cfg();
      push(C1, 32'd1); send(P1);
      push(C2, 32'd2); send(P2);
      drain();
      cfg(1'b1, 1'b1, K1, IV);
      wait_cfg();
      push(P1, 32'd1); send(C1);
      push(P2, 32'd2); send(C2);
      drain();

      // Abort mid-RUN: no output, counter cleared, chain back to IV.
      cfg(1'b0, 1'b1, K1, IV);
      wait_cfg();
      push(C1, 32'd1); send(P1);
      drain();
      core_lat = 20;
      send(P2);
      repeat (4) tick();
      out_seen = 1'b0;
      cfg(1'b0, 1'b1, K1, IV);
      wait_cfg();
      chk("abort_block_cnt", {224'h0, o_block_cnt}, 256'h0);
      repeat (25) tick();
      chk("abort_no_output", {255'h0, out_seen}, 256'h0);
      core_lat = 3;
      push(C1, 32'd1); send(P1);
      drain();

      // Key never ready: error after TO+1 waiting cycles, then recovery.
      kr_mode = 1;
      cfg(1'b0, 1'b0, K0, 128'h0);
      repeat (TO + 1) tick();
      chk("error_not_yet", {255'h0, o_error}, 256'h0);
      tick();
      chk("error_set", {255'h0, o_error}, 256'h1);
      chk("error_cfg_done", {255'h0, o_cfg_done}, 256'h0);
      kr_mode = 0;
      cfg(1'b0, 1'b0, K0, 128'h0);
      chk("error_cleared", {255'h0, o_error}, 256'h0);
      wait_cfg();
      push(E0, 32'd1); send(D0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_chain_ctrl.md
AES_CHAIN_CTRL -- requirements
Module: aes_chain_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1023: maximum cycles allowed waiting on any core response before an error is flagged.
REQ-002 Parameter CNT_W, default 32: width of the processed-block counter.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 i_cfg_start  in  1  one-cycle pulse; latches all cfg inputs and starts key expansion.
REQ-006 i_ende / i_key_mode / i_chain  in  1/2/1  cfg: 0 enc, 1 dec / 0 128, 1 192, 2 256 / 0 ECB, 1 CBC.
REQ-007 i_key / i_iv  in  256/128  key, MSB-aligned with zero padding; initial chaining value.
REQ-008 i_data, i_data_valid, o_data_ready  in/in/out  128/1/1  host input block; valid/ready handshake.
REQ-009 o_data, o_data_valid, i_data_ready  out/out/in  128/1/1  host output block; valid/ready handshake.
REQ-010 o_cfg_done, o_error, o_block_cnt  out  1/1/CNT_W  key ready for data; sticky timeout flag; blocks delivered since cfg.
REQ-011 o_core_start, o_core_enable, o_core_ende, o_core_key, o_core_key_mode  out  1/1/1/256/2  drive AES core key port.
REQ-012 o_core_data, o_core_data_valid  out  128/1  block to core; i_core_data, i_core_data_valid, i_core_key_ready  in  128/1/1  from core.

Function
REQ-013 FSM states: IDLE, KEY_REQ, KEY_WAIT, RDY, RUN, HOLD, ERR.
REQ-014 IDLE --i_cfg_start--> KEY_REQ; KEY_REQ asserts o_core_start for exactly 1 cycle, then KEY_WAIT.
REQ-015 KEY_WAIT -> RDY when i_core_key_ready=1 on or after the 2nd cycle after o_core_start; sets o_cfg_done=1 and clears o_block_cnt.
REQ-016 In RDY only, o_data_ready=1; accepting a block (valid & ready) pulses o_core_data_valid the next cycle, then RUN.
REQ-017 Core input: ECB -> i_data; CBC enc -> i_data XOR chain; CBC dec -> i_data.
REQ-018 RUN -> HOLD on i_core_data_valid; o_data = core result (ECB, CBC enc) or result XOR chain (CBC dec); o_data_valid=1.
REQ-019 Chain update at handshake: CBC enc chain <= output block; CBC dec chain <= accepted input ciphertext, stored at acceptance.
REQ-020 HOLD holds o_data stable until i_data_ready=1; on transfer o_block_cnt increments (wraps modulo 2^CNT_W), state -> RDY.
REQ-021 One block in flight; throughput is bounded by core latency plus 2 cycles.
REQ-022 Timeout counter resets on each state entry; exceeding TIMEOUT_CYC in KEY_WAIT or RUN -> ERR: o_error=1, o_cfg_done=0.
REQ-023 i_cfg_start in any state (including ERR, RUN, HOLD) aborts, discards any in-flight or held block, clears o_error, reloads chain from i_iv -> KEY_REQ.
REQ-024 i_core_data_valid outside RUN is ignored.
REQ-025 o_core_enable=1 whenever not in reset; o_core_ende/key/key_mode driven from latched cfg registers.

Reset
REQ-026 On reset low: state IDLE; o_data_ready, o_data_valid, o_cfg_done, o_error, o_core_start, o_core_data_valid = 0.
REQ-027 On reset low: o_block_cnt, chain, and all data/key registers = 0; o_core_enable = 0.
REQ-028 Reset deasserts asynchronously to clk; first i_cfg_start is honoured no earlier than the 1st clk edge after release.

Structure
REQ-029 Shared package aes_ctrl_pkg holds the FSM state encoding, chain-mode constants (ECB=0, CBC=1), and key-mode constants.
REQ-030 One sub-module, aes_ctrl_wdog, implements the loadable timeout counter; the AES core is instantiated outside this block.

Verification
REQ-031 ECB enc, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> o_data 69c4e0d86a7b0430d8cdb78070b4c55a, o_block_cnt=1.
REQ-032 CBC enc, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102..0f, P1 6bc1bee22e409f96e93d7e117393172a, P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2.
REQ-033 CBC dec of the REQ-032 ciphertexts -> plaintexts of REQ-032, in order.
REQ-034 Hold i_data_ready=0 for 20 cycles -> o_data stable, o_data_ready=0, no second core request.
REQ-035 Core model never asserts i_core_key_ready -> o_error=1 after TIMEOUT_CYC+1 cycles; a new i_cfg_start clears o_error and recovers.
REQ-036 i_cfg_start mid-RUN -> held result is discarded, no o_data_valid, chain reloaded from i_iv, o_block_cnt=0.
